// File: rtl/tt_sweep_pkg.sv
// Shared constants and state encoding for the truth-table sweep controller.
// Optional build macro used by the controller: TT_SWEEP_ONSET_EN.
package tt_sweep_pkg;

    localparam int TT_W      = 128;
    localparam int MINTERM_W = 7;
    localparam int SETTLE_W  = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD   = 3'd1;
    localparam state_t HOLD   = 3'd2;
    localparam state_t SAMPLE = 3'd3;
    localparam state_t FIN    = 3'd4;

endpackage

// File: rtl/tt_sweep_cnt.sv
// Minterm counter plus settle down-counter for the truth-table sweep.
// Priority of controls: clear > load > step > dec.
module tt_sweep_cnt
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 step,
    input  logic                 dec,
    output logic [MINTERM_W-1:0] x,
    output logic                 last,
    output logic                 settle_zero
);

    localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] settle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            settle <= '0;
        end else if (clear) begin
            x      <= '0;
            settle <= '0;
        end else if (load) begin
            x      <= '0;
            settle <= RELOAD;
        end else if (step) begin
            x      <= x + 1'b1;
            settle <= RELOAD;
        end else if (dec) begin
            settle <= settle - 1'b1;
        end
    end

    assign last        = &x;
    assign settle_zero = (settle == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps a 7-input function block through all minterms, captures its truth
// table and compares it to exp_tt. Optional onset count: TT_SWEEP_ONSET_EN.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [TT_W-1:0]  exp_tt,
    output logic [N_IN-1:0]  x,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  tt,
    output logic             match,
`ifdef TT_SWEEP_ONSET_EN
    output logic [7:0]       onset,
`endif
    output state_t           state
);

    logic [TT_W-1:0] exp_q;
    logic            last;
    logic            settle_zero;
    logic            kill;

    // abort only has an effect once a sweep is running
    assign kill = abort && (state != IDLE);

    tt_sweep_cnt #(.SETTLE(SETTLE)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (kill || (state == FIN)),
        .load        (state == LOAD),
        .step        ((state == SAMPLE) && !last),
        .dec         ((state == HOLD) && !settle_zero),
        .x           (x),
        .last        (last),
        .settle_zero (settle_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            match <= 1'b0;
            tt    <= '0;
            exp_q <= '0;
`ifdef TT_SWEEP_ONSET_EN
            onset <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
                match <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                            match <= 1'b0;
                            exp_q <= exp_tt;
                            tt    <= '0;
`ifdef TT_SWEEP_ONSET_EN
                            onset <= '0;
`endif
                        end
                    end
                    LOAD: state <= HOLD;
                    HOLD: begin
                        if (settle_zero) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        tt[x] <= f_in;
`ifdef TT_SWEEP_ONSET_EN
                        onset <= onset + 8'(f_in);
`endif
                        state <= last ? FIN : HOLD;
                    end
                    FIN: begin
                        // last sample landed on the edge into FIN, so tt is complete here
                        match <= (tt == exp_q);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
